// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, one partial product per cycle.
// Operands enter through an in_valid/in_ready handshake, the 2*WIDTH-bit product
// leaves through out_valid/out_ready. A transfer happens on a rising edge where
// valid && ready are both high; a producer holds its data stable until then.
// Optional macro: SEQ_MULT_SIGNED_EN adds the sgn input for two's-complement
// operands (magnitudes are multiplied, the product is negated at the z load).
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_z;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_z_next;
    logic             w_last;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;
    logic w_a_neg;
    logic w_b_neg;

    // Magnitudes of the operands; the most-negative value maps onto itself, which
    // is exactly 2^(WIDTH-1) when read back as unsigned.
    always_comb begin
        w_a_neg = sgn & a[WIDTH-1];
        w_b_neg = sgn & b[WIDTH-1];
        w_a_mag = w_a_neg ? (-a) : a;
        w_b_mag = w_b_neg ? (-b) : b;
        w_z_next = r_neg ? (-w_acc_next) : w_acc_next;
    end
`else
    // Unsigned only: operands and result pass straight through.
    always_comb begin
        w_a_mag  = a;
        w_b_mag  = b;
        w_z_next = w_acc_next;
    end
`endif

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
        w_last     = (r_count == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_z         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            r_neg       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier   <= w_b_mag;
                        r_acc      <= '0;
                        r_count    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        r_neg      <= w_a_neg ^ w_b_neg;
`endif
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[PW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_z         <= w_z_next;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // z is left untouched on handoff so the last product stays visible.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign z         = r_z;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=8 main instance with product scoreboard,
// plus WIDTH=16 and WIDTH=2 instances for width corner cases.
module tb_seq_multiplier;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] z;
    logic        busy;
    logic [1:0]  dbg_state;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn(sgn),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- WIDTH=16 instance ----------------
    logic        in16_valid = 1'b0;
    logic        in16_ready;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        out16_valid;
    logic        out16_ready = 1'b1;
    logic [31:0] z16;
    logic        busy16;
    logic [1:0]  dbg16;

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in16_valid), .in_ready(in16_ready),
        .a(a16), .b(b16),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn(1'b0),
`endif
        .out_valid(out16_valid), .out_ready(out16_ready),
        .z(z16), .busy(busy16), .dbg_state(dbg16)
    );

    // ---------------- WIDTH=2 instance ----------------
    logic        in2_valid = 1'b0;
    logic        in2_ready;
    logic [1:0]  a2 = '0;
    logic [1:0]  b2 = '0;
    logic        out2_valid;
    logic        out2_ready = 1'b1;
    logic [3:0]  z2;
    logic        busy2;
    logic [1:0]  dbg2;

    seq_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in2_valid), .in_ready(in2_ready),
        .a(a2), .b(b2),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn(1'b0),
`endif
        .out_valid(out2_valid), .out_ready(out2_ready),
        .z(z2), .busy(busy2), .dbg_state(dbg2)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    int n_products = 0;
    logic rand_ready = 1'b0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // Inputs change 2 time units after a rising edge, outputs are read there too.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: the mathematical product, signed when s is set.
    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        longint px;
        longint py;
        px = (s && x[7]) ? longint'(x) - 256 : longint'(x);
        py = (s && y[7]) ? longint'(y) - 256 : longint'(y);
        return 16'(px * py);
    endfunction

    // ---------------- scoreboard: every handed-off product ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_product");
            end else begin
                check("product", 64'(z), 64'(exp_q.pop_front()));
            end
            n_products++;
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] ez);
        int n;
        int base;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) timeout("wait_in_ready");
        exp_q.push_back(ez);
        base = n_products;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        n = 0;
        while (n_products == base && n < 200) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        out_ready = 1'b1;
        if (n_products == base) timeout("wait_product");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int lat;
        int base;
        int n;
        vecs[0] = '{8'd255, 8'd255, 16'hFE01};
        vecs[1] = '{8'h00,  8'hA5,  16'h0000};
        vecs[2] = '{8'h0F,  8'h11,  16'h00FF};
        vecs[3] = '{8'd12,  8'd10,  16'd120};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'h80,  8'd2,   16'h0100};
        vecs[6] = '{8'hAA,  8'h55,  16'h3872};
        vecs[7] = '{8'd255, 8'd0,   16'd0};

        // ---- reset ----
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_z", 64'(z), 64'd0);
        check("rst_state_idle", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;

        // ---- latency and handoff: 255*255 ----
        exp_q.push_back(16'hFE01);
        a = 8'd255;
        b = 8'd255;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_busy", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
            if (!out_valid) check("busy_during", 64'(busy), 64'd1);
        end
        check("latency_w8", 64'(lat), 64'd8);
        check("z_ffxff", 64'(z), 64'hFE01);
        check("busy_in_done", 64'(busy), 64'd0);
        check("in_ready_done", 64'(in_ready), 64'd0);
        step();
        check("in_ready_after_handoff", 64'(in_ready), 64'd1);
        check("out_valid_after_handoff", 64'(out_valid), 64'd0);
        check("z_kept_after_handoff", 64'(z), 64'hFE01);

        // ---- back-to-back with in_valid held high ----
        base = n_products;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h00FF);
        a = 8'h00;
        b = 8'hA5;
        in_valid = 1'b1;
        step();
        a = 8'h0F;
        b = 8'h11;
        repeat (10) step();
        in_valid = 1'b0;
        check("second_op_running", 64'(busy), 64'd1);
        n = 0;
        while (n_products < base + 2 && n < 40) begin
            step();
            n++;
        end
        repeat (15) step();
        check("b2b_product_count", 64'(n_products - base), 64'd2);

        // ---- backpressure: 12*10 held for 5 cycles ----
        out_ready = 1'b0;
        base = n_products;
        exp_q.push_back(16'd120);
        a = 8'd12;
        b = 8'd10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) timeout("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_z_stable", 64'(z), 64'd120);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_high", 64'(out_valid), 64'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_handoff_first_edge", 64'(out_valid), 64'd0);
        check("bp_one_product", 64'(n_products - base), 64'd1);

        // ---- reset during the 4th BUSY cycle of 200*3 ----
        a = 8'd200;
        b = 8'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_z", 64'(z), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        do_op(8'd2, 8'd3, 16'd6);
        check("post_rst_z", 64'(z), 64'd6);

        // ---- table vectors ----
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].z);
            check("vec_z", 64'(z), 64'(vecs[i].z));
        end

        // ---- randomized against model, random backpressure ----
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, model(ra, rb, 1'b0));
        end
        rand_ready = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
        // ---- signed mode ----
        sgn = 1'b1;
        do_op(8'h80, 8'h80, 16'h4000);
        check("s_80x80", 64'(z), 64'h4000);
        do_op(8'hFF, 8'h01, 16'hFFFF);
        check("s_ffx01", 64'(z), 64'hFFFF);
        do_op(8'h7F, 8'h80, 16'hC080);
        check("s_7fx80", 64'(z), 64'hC080);
        sgn = 1'b0;
        do_op(8'hFF, 8'h01, 16'h00FF);
        check("u_ffx01", 64'(z), 64'h00FF);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            sgn = 1'($urandom_range(0, 1));
            do_op(ra, rb, model(ra, rb, sgn));
        end
        sgn = 1'b0;
`endif

        // ---- WIDTH=16: 0xFFFF*0xFFFF ----
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        in16_valid = 1'b1;
        step();
        in16_valid = 1'b0;
        lat = 0;
        while (!out16_valid && lat < 60) begin
            step();
            lat++;
        end
        check("latency_w16", 64'(lat), 64'd16);
        check("z_w16", 64'(z16), 64'hFFFE0001);
        step();

        // ---- WIDTH=2: all operand pairs ----
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                n = 0;
                while (!in2_ready && n < 20) begin
                    step();
                    n++;
                end
                a2 = 2'(i);
                b2 = 2'(j);
                in2_valid = 1'b1;
                step();
                in2_valid = 1'b0;
                lat = 0;
                while (!out2_valid && lat < 20) begin
                    step();
                    lat++;
                end
                check("latency_w2", 64'(lat), 64'd2);
                check("z_w2", 64'(z2), 64'(i * j));
            end
        end
        step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
